// File: rtl/receptor_caractere_if.sv
// Serial character receiver bus: serial line in, character/status/strobe out.
interface receptor_caractere_if;
  logic       rx;
  logic [4:0] caractere;
  logic       erro;
  logic       pronto;

  // Line driver and result consumer side
  modport master (
    output rx,
    input  caractere,
    input  erro,
    input  pronto
  );

  // Receiver side
  modport slave (
    input  rx,
    output caractere,
    output erro,
    output pronto
  );
endinterface

// File: rtl/receptor_caractere.sv
// Serial receiver for 5-bit character codes (0..19): start, 5 data LSB first,
// even parity, stop. Reports the last valid code and a frame-status flag.
module receptor_caractere #(
  parameter int unsigned CLKS_POR_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  receptor_caractere_if.slave   bus
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CODE_W   = 5;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_POR_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_POR_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(19);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA,
    ESPERA_ALTO
  } estado_t;

  estado_t           estado;
  logic              rx_m;
  logic              rx_s;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] shreg;
  logic              erro_par;
  logic [CODE_W-1:0] caractere_q;
  logic              erro_q;
  logic              pronto_q;

  assign bus.caractere = caractere_q;
  assign bus.erro      = erro_q;
  assign bus.pronto    = pronto_q;

  // Two-flop synchronizer; idles high like the line itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM with bit timing, shift register and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      erro_par    <= 1'b0;
      caractere_q <= 5'b11111;
      erro_q      <= 1'b1;
      pronto_q    <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (!rx_s) begin
            estado <= INICIO;
            cnt    <= '0;
          end
        end
        INICIO: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // A high line at mid start bit was a glitch
            estado <= rx_s ? OCIOSO : DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[CODE_W-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              estado <= PARIDADE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            erro_par <= (^shreg) ^ rx_s;
            estado   <= PARADA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARADA: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            pronto_q <= 1'b1;
            if (!erro_par && rx_s && (shreg <= CODE_MAX)) begin
              caractere_q <= shreg;
              erro_q      <= 1'b1;
            end else begin
              erro_q <= 1'b0;
            end
            // A low stop bit may be a break; wait for the line to rise
            estado <= rx_s ? OCIOSO : ESPERA_ALTO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESPERA_ALTO: begin
          if (rx_s) begin
            estado <= OCIOSO;
          end
        end
        default: begin
          estado <= OCIOSO;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_caractere.sv
// Directed bench for receptor_caractere at 4 clocks per bit.
module tb_receptor_caractere;

  localparam int unsigned CPB = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_pronto;
  int   base;

  receptor_caractere_if bus ();

  receptor_caractere #(.CLKS_POR_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with pronto high, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.pronto === 1'b1) n_pronto++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_cycles(CPB);
  endtask

  // Full frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [4:0] code, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic frame_and_check(input string tag, input logic [4:0] code, input logic par,
                                 input logic [4:0] exp_car, input logic exp_erro);
    base = n_pronto;
    send_frame(code, par, 1'b1);
    wait_cycles(6);
    check({tag, "_pronto"}, 32'(n_pronto - base), 32'd1);
    check({tag, "_car"}, 32'(bus.caractere), 32'(exp_car));
    check({tag, "_erro"}, 32'(bus.erro), 32'(exp_erro));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pronto = 0;
    bus.rx   = 1'b1;
    rst_n    = 1'b0;
    wait_cycles(3);
    check("rst_car", 32'(bus.caractere), 32'h1f);
    check("rst_erro", 32'(bus.erro), 32'd1);
    check("rst_pronto", 32'(bus.pronto), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    frame_and_check("f01110", 5'b01110, 1'b1, 5'b01110, 1'b1);
    frame_and_check("badpar", 5'b00101, 1'b1, 5'b01110, 1'b0);
    frame_and_check("code20", 5'b10100, 1'b0, 5'b01110, 1'b0);
    frame_and_check("code0", 5'b00000, 1'b0, 5'b00000, 1'b1);
    frame_and_check("code19", 5'b10011, 1'b1, 5'b10011, 1'b1);

    // One-cycle low glitch must not start a frame
    base   = n_pronto;
    bus.rx = 1'b0;
    wait_cycles(1);
    bus.rx = 1'b1;
    wait_cycles(40);
    check("glitch_pronto", 32'(n_pronto - base), 32'd0);
    check("glitch_car", 32'(bus.caractere), 32'h13);
    check("glitch_erro", 32'(bus.erro), 32'd1);

    // Low stop bit followed by a break held low
    base = n_pronto;
    send_frame(5'b00011, 1'b0, 1'b0);
    wait_cycles(20);
    check("brk_pronto", 32'(n_pronto - base), 32'd1);
    check("brk_erro", 32'(bus.erro), 32'd0);
    check("brk_car", 32'(bus.caractere), 32'h13);
    wait_cycles(20);
    check("brk_hold", 32'(n_pronto - base), 32'd1);
    bus.rx = 1'b1;
    wait_cycles(6);
    frame_and_check("post_brk", 5'b00001, 1'b1, 5'b00001, 1'b1);

    // Reset in the middle of the data bits
    base = n_pronto;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    #1;
    check("mid_rst_car", 32'(bus.caractere), 32'h1f);
    check("mid_rst_erro", 32'(bus.erro), 32'd1);
    check("mid_rst_pronto", 32'(bus.pronto), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(40);
    check("abort_pronto", 32'(n_pronto - base), 32'd0);
    check("abort_car", 32'(bus.caractere), 32'h1f);
    frame_and_check("after_rst", 5'b01010, 1'b0, 5'b01010, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/receptor_caractere.md
RECEPTOR_CARACTERE -- requirements
Module: receptor_caractere

Interface
REQ-001 Parameter CLKS_POR_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line, idle high.
REQ-005 caractere  output  5  last accepted character code (0..19), registered.
REQ-006 erro  output  1  frame status, registered: 1 = last frame valid, 0 = last frame in error (display-stage convention: 0 shows "E").
REQ-007 pronto  output  1  one-cycle pulse per completed frame, valid or not.

Function
REQ-008 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized rx_s only.
REQ-009 Frame SHALL be: start bit (0), 5 data bits LSB first, even-parity bit, stop bit (1).
REQ-010 FSM states SHALL be OCIOSO, INICIO, DADOS, PARIDADE, PARADA, ESPERA_ALTO.
REQ-011 OCIOSO: on rx_s=0, go to INICIO and clear the bit-cycle counter.
REQ-012 INICIO: at counter = CLKS_POR_BIT/2 - 1 (integer division), resample rx_s; if 0, go to DADOS with counter cleared; if 1 (glitch), return to OCIOSO with no output activity.
REQ-013 DADOS: sample rx_s when counter = CLKS_POR_BIT-1, shift it into a 5-bit register LSB first, clear the counter; after the 5th sample go to PARIDADE.
REQ-014 PARIDADE: sample once at counter = CLKS_POR_BIT-1; flag parity error if XOR of the 5 data bits and the parity bit is 1; go to PARADA.
REQ-015 PARADA: sample once at counter = CLKS_POR_BIT-1; flag stop error if rx_s = 0.
REQ-016 On the PARADA sample edge, the frame SHALL complete: pronto = 1 for exactly that next cycle, erro and caractere updated on the same edge.
REQ-017 Frame valid iff parity ok, stop = 1 and code <= 5'b10011; then caractere = code, erro = 1.
REQ-018 Invalid frame: erro = 0, caractere holds its previous value.
REQ-019 On frame completion, next state SHALL be OCIOSO if stop sample = 1, else ESPERA_ALTO.
REQ-020 ESPERA_ALTO: remain until rx_s = 1, then OCIOSO; no start detection while rx_s stays low (break condition).
REQ-021 Error priority irrelevant: any error gives erro = 0; no error-kind output.
REQ-022 caractere and erro SHALL hold between frames; pronto = 0 whenever no frame completes.
REQ-023 Bit-cycle counter width = 8 bits; must never wrap within a bit period.
REQ-024 Nominal latency: 2-cycle synchronizer plus (0.5 + 7) bit periods from the falling start edge to the stop sample, plus 1 cycle to the outputs.

Reset
REQ-025 While rst_n = 0: state OCIOSO, counters 0, shift register 0, synchronizer flops 1, caractere = 5'b11111, erro = 1, pronto = 0 (display stage shows blank).
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pronto pulse; after release, reception restarts only on a new start bit.

Verification (CLKS_POR_BIT = 4)
REQ-027 Frame with code 5'b01110, parity 1, stop 1 -> single pronto pulse, caractere = 5'b01110, erro = 1.
REQ-028 Code 5'b00101 sent with wrong parity (1) -> pronto pulse, erro = 0, caractere keeps previous value 5'b01110.
REQ-029 Code 5'b10100 (20), correct parity 0, stop 1 -> erro = 0, caractere unchanged; then frame with code 0 -> caractere = 0, erro = 1.
REQ-030 rx low for 1 cycle only -> INICIO aborts, no pronto, outputs unchanged.
REQ-031 Stop bit 0, rx then held low 20 cycles -> erro = 0, no further pronto until rx returns high and a new start arrives.
REQ-032 rst_n pulsed low during DADOS -> outputs 5'b11111 / 1 / 0 immediately; no pronto for the aborted frame; next full frame received correctly.
